// File: rtl/hazard_mem_ctrl.sv
// RV32I pipeline hazard unit: stall/flush/forward controls plus one-shot dmem request/ack sequencing.
// Controls are combinational (zero latency); the MEM access freezes the pipeline until ack, or forever after timeout.
module hazard_mem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      rs1D_i,
  input  logic [4:0]      rs2D_i,
  input  logic [4:0]      rs1E_i,
  input  logic [4:0]      rs2E_i,
  input  logic [4:0]      rdE_i,
  input  logic            loadE_i,
  input  logic            pcsrcE_i,
  input  logic [4:0]      rdM_i,
  input  logic            regwriteM_i,
  input  logic [4:0]      rdW_i,
  input  logic            regwriteW_i,
  input  logic            memreqM_i,
  input  logic            dmem_ack_i,
  output logic            dmem_req_o,
  output logic            stallF_o,
  output logic            stallD_o,
  output logic            stallE_o,
  output logic            stallM_o,
  output logic            flushD_o,
  output logic            flushE_o,
  output logic            flushW_o,
  output logic [1:0]      forwardAE_o,
  output logic [1:0]      forwardBE_o,
  output logic            error_o,
  output logic [CNTW-1:0] stall_cnt_o
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            error_q, error_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  logic memstall;
  logic req;
  logic load_use;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    error_d  = error_q;
    memstall = 1'b0;
    req      = 1'b0;
    case (state_q)
      RUN: begin
        if (memreqM_i) begin
          req      = 1'b1;
          memstall = 1'b1;
          state_d  = WAIT;
          wait_d   = '0;
        end
      end
      WAIT: begin
        if (dmem_ack_i) begin
          state_d = RUN;
        end else begin
          memstall = 1'b1;
          // wait_q counts completed unacked WAIT cycles; this is the TIMEOUT-th one
          if (wait_q == WW'(TIMEOUT - 1)) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
      end
      ERR: begin
        memstall = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (regwriteM_i && (rdM_i != 5'd0) && (rdM_i == rs))
      fwd_sel = 2'b10;
    else if (regwriteW_i && (rdW_i != 5'd0) && (rdW_i == rs))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  assign load_use = loadE_i && (rdE_i != 5'd0) && ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

  always_comb begin
    dmem_req_o  = 1'b0;
    stallF_o    = 1'b0;
    stallD_o    = 1'b0;
    stallE_o    = 1'b0;
    stallM_o    = 1'b0;
    flushD_o    = 1'b0;
    flushE_o    = 1'b0;
    flushW_o    = 1'b0;
    forwardAE_o = 2'b00;
    forwardBE_o = 2'b00;
    if (rst_i) begin
      dmem_req_o  = req;
      forwardAE_o = fwd_sel(rs1E_i);
      forwardBE_o = fwd_sel(rs2E_i);
      if (memstall) begin
        // Whole pipe frozen; branch/load-use are deferred until memory completes
        stallF_o = 1'b1;
        stallD_o = 1'b1;
        stallE_o = 1'b1;
        stallM_o = 1'b1;
        flushW_o = 1'b1;
      end else begin
        flushD_o = pcsrcE_i;
        flushE_o = pcsrcE_i || load_use;
        stallF_o = load_use && !pcsrcE_i;
        stallD_o = load_use && !pcsrcE_i;
      end
    end
  end

  assign stall_cnt_d = stall_cnt_q + CNTW'(stallF_o);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      wait_q      <= '0;
      error_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      error_q     <= error_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign error_o     = error_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_mem_ctrl.sv
// Directed and randomized checks of hazard_mem_ctrl against a behavioural reference model.
module tb_hazard_mem_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNTW    = 32;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [4:0]      rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i;
  logic            loadE_i, pcsrcE_i, regwriteM_i, regwriteW_i, memreqM_i, dmem_ack_i;
  logic            dmem_req_o, stallF_o, stallD_o, stallE_o, stallM_o;
  logic            flushD_o, flushE_o, flushW_o, error_o;
  logic [1:0]      forwardAE_o, forwardBE_o;
  logic [CNTW-1:0] stall_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: is an access outstanding, how long it has waited, has it timed out
  bit          m_busy;
  int          m_waited;
  bit          m_err;
  logic [31:0] m_cnt;

  hazard_mem_ctrl #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rs1D_i(rs1D_i), .rs2D_i(rs2D_i), .rs1E_i(rs1E_i), .rs2E_i(rs2E_i),
    .rdE_i(rdE_i), .loadE_i(loadE_i), .pcsrcE_i(pcsrcE_i),
    .rdM_i(rdM_i), .regwriteM_i(regwriteM_i), .rdW_i(rdW_i), .regwriteW_i(regwriteW_i),
    .memreqM_i(memreqM_i), .dmem_ack_i(dmem_ack_i), .dmem_req_o(dmem_req_o),
    .stallF_o(stallF_o), .stallD_o(stallD_o), .stallE_o(stallE_o), .stallM_o(stallM_o),
    .flushD_o(flushD_o), .flushE_o(flushE_o), .flushW_o(flushW_o),
    .forwardAE_o(forwardAE_o), .forwardBE_o(forwardBE_o),
    .error_o(error_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs != 0 && regwriteM_i && rdM_i == rs) return 2'b10;
    if (rs != 0 && regwriteW_i && rdW_i == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    {rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i} = '0;
    {loadE_i, pcsrcE_i, regwriteM_i, regwriteW_i, memreqM_i, dmem_ack_i} = '0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_waited = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, dmem_req_o, 0);
    chk({tag, "_stall"}, {stallF_o, stallD_o, stallE_o, stallM_o}, 0);
    chk({tag, "_flush"}, {flushD_o, flushE_o, flushW_o}, 0);
    chk({tag, "_fwd"}, {forwardAE_o, forwardBE_o}, 0);
    chk({tag, "_err"}, error_o, 0);
    chk({tag, "_cnt"}, stall_cnt_o, 0);
  endtask

  // Called just after a negedge with inputs set: checks outputs, clocks once, advances model.
  task automatic cycle(input string tag);
    bit frozen, lu, e_req, sF;
    e_req  = !m_err && !m_busy && memreqM_i;
    frozen = m_err || (m_busy ? !dmem_ack_i : memreqM_i);
    lu     = loadE_i && rdE_i != 0 && (rdE_i == rs1D_i || rdE_i == rs2D_i);
    sF     = frozen || (lu && !pcsrcE_i);
    #1;
    chk({tag, "_req"}, dmem_req_o, e_req);
    chk({tag, "_stallFD"}, {stallF_o, stallD_o}, {sF, sF});
    chk({tag, "_stallEM"}, {stallE_o, stallM_o}, {frozen, frozen});
    chk({tag, "_flushD"}, flushD_o, !frozen && pcsrcE_i);
    chk({tag, "_flushE"}, flushE_o, !frozen && (pcsrcE_i || lu));
    chk({tag, "_flushW"}, flushW_o, frozen);
    chk({tag, "_fwdA"}, forwardAE_o, ref_fwd(rs1E_i));
    chk({tag, "_fwdB"}, forwardBE_o, ref_fwd(rs2E_i));
    @(posedge clk);
    if (sF) m_cnt = m_cnt + 1;
    if (!m_err) begin
      if (m_busy) begin
        if (dmem_ack_i) m_busy = 0;
        else begin
          m_waited++;
          if (m_waited == TIMEOUT) begin m_err = 1; m_busy = 0; end
        end
      end else if (memreqM_i) begin
        m_busy = 1; m_waited = 0;
      end
    end
    #1;
    chk({tag, "_cnt"}, stall_cnt_o, m_cnt);
    chk({tag, "_err"}, error_o, m_err);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    memreqM_i = 1'b1; loadE_i = 1'b1; rdE_i = 5'd3; rs1D_i = 5'd3; pcsrcE_i = 1'b1;
    regwriteM_i = 1'b1; rdM_i = 5'd4; rs1E_i = 5'd4;
    #1;
    check_all_zero("rst");
    model_reset();
    @(negedge clk);
    clear_inputs();
    rst_i = 1'b1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Forwarding
    regwriteM_i = 1; rdM_i = 5; regwriteW_i = 1; rdW_i = 5; rs1E_i = 5; rs2E_i = 5;
    cycle("fwd_mem_prio");
    chk("fwd_mem_prio_A", forwardAE_o, 2'b10);
    rs1E_i = 0;
    cycle("fwd_x0");
    chk("fwd_x0_A", forwardAE_o, 2'b00);
    rs1E_i = 5; regwriteM_i = 0;
    cycle("fwd_wb_only");
    chk("fwd_wb_only_A", forwardAE_o, 2'b01);
    clear_inputs();

    // Load-use, then load-use with branch
    loadE_i = 1; rdE_i = 7; rs2D_i = 7;
    cycle("ldu");
    pcsrcE_i = 1;
    cycle("ldu_br");
    clear_inputs();
    cycle("idle");

    // Handshake: request cycle 0, ack cycle 3
    do_reset();
    memreqM_i = 1;
    cycle("hs_c0");
    cycle("hs_c1");
    cycle("hs_c2");
    dmem_ack_i = 1;
    cycle("hs_c3");
    chk("hs_cnt3", stall_cnt_o, 3);
    clear_inputs();
    cycle("hs_after");

    // Back-to-back loads, ack one cycle after each request
    memreqM_i = 1;
    for (int i = 0; i < 6; i++) begin
      dmem_ack_i = i[0];
      cycle("b2b");
    end
    clear_inputs();
    cycle("b2b_end");
    chk("b2b_noerr", error_o, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rs1D_i = 5'($urandom_range(0, 3)); rs2D_i = 5'($urandom_range(0, 3));
      rs1E_i = 5'($urandom_range(0, 3)); rs2E_i = 5'($urandom_range(0, 3));
      rdE_i  = 5'($urandom_range(0, 3)); rdM_i  = 5'($urandom_range(0, 3));
      rdW_i  = 5'($urandom_range(0, 3));
      loadE_i = 1'($urandom); pcsrcE_i = 1'($urandom_range(0, 3) == 0);
      regwriteM_i = 1'($urandom); regwriteW_i = 1'($urandom);
      memreqM_i = 1'($urandom); dmem_ack_i = 1'($urandom_range(0, 2) != 0);
      cycle("rnd");
    end

    // Timeout
    do_reset();
    memreqM_i = 1;
    cycle("to_req");
    for (int i = 1; i <= TIMEOUT; i++) begin
      cycle("to_wait");
      if (i == TIMEOUT - 1) chk("to_not_yet", error_o, 0);
    end
    chk("to_error", error_o, 1);
    dmem_ack_i = 1;
    cycle("to_late_ack");
    chk("to_stuck_stall", stallF_o, 1);
    clear_inputs();

    // Reset asserted mid-WAIT
    do_reset();
    memreqM_i = 1;
    cycle("mw_req");
    #2;
    rst_i = 1'b0;
    #1;
    check_all_zero("mw_async");
    model_reset();
    @(negedge clk);
    clear_inputs();
    rst_i = 1'b1;
    cycle("mw_idle");
    chk("mw_cnt0", stall_cnt_o, 0);
    memreqM_i = 1;
    cycle("mw_newreq");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_mem_ctrl.md
# hazard_mem_ctrl

Pipeline controller for the 5-stage RV32I core. It generates the stall, flush and forwarding controls for the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It also sequences each data-memory access in the MEM stage through a one-shot request/acknowledge handshake, freezing the pipeline until the memory answers. A sticky timeout error and a stall-cycle performance counter are included.

## Interface
Parameters:
- TIMEOUT, 16: maximum consecutive WAIT cycles without ack before error (≥2)
- CNTW, 32: width of stall performance counter

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- rs1D_i, rs2D_i  in  5 each  source registers of instruction in ID
- rs1E_i, rs2E_i  in  5 each  source registers of instruction in EX
- rdE_i  in  5  destination of instruction in EX
- loadE_i  in  1  instruction in EX is a load
- pcsrcE_i  in  1  taken branch/jump resolved in EX
- rdM_i  in  5  destination in MEM
- regwriteM_i  in  1  MEM instruction writes register file
- rdW_i  in  5  destination in WB
- regwriteW_i  in  1  WB instruction writes register file
- memreqM_i  in  1  MEM instruction is a load or store
- dmem_ack_i  in  1  data memory completion
- dmem_req_o  out  1  one-cycle request to data memory
- stallF_o, stallD_o, stallE_o, stallM_o  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM
- flushD_o, flushE_o, flushW_o  out  1 each  bubble into IF-ID / ID-EX / MEM-WB
- forwardAE_o, forwardBE_o  out  2 each  EX operand select: 00 regfile, 01 WB result, 10 MEM ALU result
- error_o  out  1  sticky memory timeout
- stall_cnt_o  out  CNTW  cycles with stallF_o high

## Operation
- FSM states: RUN, WAIT, ERR. Reset state RUN.
- RUN:
  - memreqM_i=1: dmem_req_o=1, memstall=1, next state WAIT, wait counter cleared.
  - Otherwise memstall=0.
  - dmem_ack_i is ignored in RUN.
- WAIT:
  - dmem_req_o=0.
  - dmem_ack_i=1: memstall=0 this cycle (pipeline advances, MEM result captured), next state RUN.
  - Else memstall=1 and the wait counter increments.
  - No ack within TIMEOUT consecutive WAIT cycles: next state ERR. An ack on the TIMEOUT-th cycle is accepted.
- ERR: memstall=1 permanently, error_o=1, dmem_req_o=0. Only reset exits.
- memstall=1 forces:
  - stallF/D/E/M=1, flushW=1.
  - flushD=0, flushE=0; a pending branch or load-use is acted on when memstall drops.
- memstall=0, hazard rules:
  - Load-use: loadE_i & rdE_i≠0 & (rdE_i==rs1D_i | rdE_i==rs2D_i) sets stallF=stallD=flushE=1.
  - Branch: pcsrcE_i sets flushD=flushE=1. Branch wins over load-use: stallF=stallD=0.
  - stallE=stallM=flushW=0.
- Forwarding (independent of stalls), shown for operand A; B is identical with rs2E_i:
  - 10 if regwriteM_i & rdM_i≠0 & rdM_i==rs1E_i.
  - Else 01 if regwriteW_i & rdW_i≠0 & rdW_i==rs1E_i.
  - Else 00. MEM has priority over WB.
- stall_cnt_o increments on every clock edge where stallF_o=1 and wraps modulo 2^CNTW.

## Timing
- Reset values:
  - State RUN, wait counter 0, stall_cnt_o=0, error_o=0.
  - While rst_i=0, every stall/flush output and dmem_req_o is forced 0; forward outputs are 0.
- Reset assertion mid-access (WAIT or ERR) aborts immediately. After release, the FSM is in RUN and a new request issues only on memreqM_i.
- All stall, flush, forward and dmem_req_o outputs are combinational from state and inputs, with zero-cycle latency.
- State, counters and error_o are registered.
- Minimum access: request in cycle n, ack at n+1 gives 1 stall cycle. Ack cannot be honoured in cycle n.
- Back-to-back accesses: after ack at cycle k, the next MEM instruction requests at k+1; dmem_req_o is never high two consecutive cycles.
- error_o rises on the clock edge ending the TIMEOUT-th unacked WAIT cycle.

## Test plan
- Forwarding: rdM=5 with regwriteM, rdW=5 with regwriteW, rs1E=5 gives forwardAE=10. With rs1E=0, gives 00. With only the W match, gives 01.
- Load-use: loadE=1, rdE=7, rs2D=7 gives stallF=stallD=flushE=1 for one cycle. Adding pcsrcE=1 in the same cycle gives flushD=flushE=1 and stallF=0.
- Memory handshake:
  - memreqM=1 at cycle 0 gives dmem_req_o=1 only at cycle 0.
  - Ack at cycle 3 gives stalls high for cycles 0–2 and low at cycle 3.
  - stall_cnt_o=3 afterwards.
- Back-to-back loads with ack always 1 cycle later give the request pattern 1,0,1,0 and no timeout.
- Timeout with TIMEOUT=16: no ack gives error_o=1 after cycle 16. A later ack is ignored and stalls remain high.
- Reset mid-WAIT drops all outputs to 0 asynchronously. After release, state is RUN and stall_cnt_o=0.
